// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU control sequencer: opcode encoding, IR field
// positions, FSM state type and opcode-class helpers.
package alu_seq_pkg;

  localparam int OPC_W   = 5;
  localparam int FIELD_W = 4;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  localparam logic [OPC_W-1:0] OP_AND  = 5'd0;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd1;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd2;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd3;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd4;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'd5;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'd7;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'd8;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'd9;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'd10;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'd11;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd12;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_ERR
  } seq_state_t;

  function automatic logic op_is_wide(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_unary(input logic [OPC_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic op_is_illegal(input logic [OPC_W-1:0] op);
    return op > OP_NOT;
  endfunction

endpackage

// File: rtl/ir_class_decode.sv
// Combinational IR decode: register fields plus opcode class flags.
module ir_class_decode
  import alu_seq_pkg::*;
#(
  parameter int IR_W = 32
) (
  input  logic [IR_W-1:0]    ir,
  output logic [OPC_W-1:0]   op,
  output logic [FIELD_W-1:0] ra,
  output logic [FIELD_W-1:0] rb,
  output logic [FIELD_W-1:0] rc,
  output logic               is_wide,
  output logic               is_unary,
  output logic               is_illegal
);

  // Low immediate bits are irrelevant to register-format instructions.
  logic ir_unused;
  assign ir_unused = ^ir;

  assign op         = ir[OPC_LSB +: OPC_W];
  assign ra         = ir[RA_LSB +: FIELD_W];
  assign rb         = ir[RB_LSB +: FIELD_W];
  assign rc         = ir[RC_LSB +: FIELD_W];
  assign is_wide    = op_is_wide(op);
  assign is_unary   = op_is_unary(op);
  assign is_illegal = op_is_illegal(op);

endmodule

// File: rtl/alu_op_sequencer.sv
// Fetch/execute control sequencer for one register-format ALU instruction.
// Optional feature: ALU_SEQ_MEM_WAIT_EN stretches T1 until mem_rdy.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int IR_W      = 32,
  parameter int REG_SEL_W = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 mem_rdy,
  input  logic [IR_W-1:0]      ir,
  output logic [4:0]           opcode,
  output logic                 IncPC,
  output logic                 PCout,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 MDRout,
  output logic                 Rout,
  output logic                 MARin,
  output logic                 PCin,
  output logic                 MDRin,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 Rin,
  output logic                 LOin,
  output logic                 HIin,
  output logic                 Read,
  output logic [REG_SEL_W-1:0] reg_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  seq_state_t state_reg, state_next;

  logic [OPC_W-1:0]   op;
  logic [FIELD_W-1:0] ra, rb, rc;
  logic               is_wide, is_unary, is_illegal;

  ir_class_decode #(.IR_W(IR_W)) u_decode (
    .ir         (ir),
    .op         (op),
    .ra         (ra),
    .rb         (rb),
    .rc         (rc),
    .is_wide    (is_wide),
    .is_unary   (is_unary),
    .is_illegal (is_illegal)
  );

`ifndef ALU_SEQ_MEM_WAIT_EN
  logic mem_rdy_unused;
  assign mem_rdy_unused = mem_rdy;
`endif

  always_ff @(posedge clock) begin
    if (clear) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
`ifdef ALU_SEQ_MEM_WAIT_EN
      ST_T1:   if (mem_rdy) state_next = ST_T2;
`else
      ST_T1:   state_next = ST_T2;
`endif
      ST_T2: begin
        if (is_illegal)    state_next = ST_ERR;
        else if (is_unary) state_next = ST_T4;
        else               state_next = ST_T3;
      end
      ST_T3:   state_next = ST_T4;
      ST_T4:   state_next = ST_T5;
      ST_T5:   state_next = is_wide ? ST_T6 : ST_IDLE;
      ST_T6:   state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    opcode   = '0;
    IncPC    = 1'b0;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    Rout     = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Rin      = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Read     = 1'b0;
    reg_sel  = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    busy     = (state_reg != ST_IDLE);
    case (state_reg)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
`ifdef ALU_SEQ_MEM_WAIT_EN
        // The incremented PC is committed only once, in the data-valid cycle.
        Zlowout = mem_rdy;
        PCin    = mem_rdy;
`else
        Zlowout = 1'b1;
        PCin    = 1'b1;
`endif
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        Rout    = 1'b1;
        Yin     = 1'b1;
        reg_sel = REG_SEL_W'(rb);
      end
      ST_T4: begin
        Rout    = 1'b1;
        Zin     = 1'b1;
        opcode  = op;
        reg_sel = is_unary ? REG_SEL_W'(rb) : REG_SEL_W'(rc);
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (is_wide) begin
          LOin = 1'b1;
        end else begin
          Rin     = 1'b1;
          reg_sel = REG_SEL_W'(ra);
          done    = 1'b1;
        end
      end
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      ST_ERR:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: per-cycle expected output vectors are
// queued when an instruction is started and popped as the DUT steps.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic [4:0] opcode;
    logic inc_pc, pc_out, zlo_out, zhi_out, mdr_out, r_out;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, z_in, r_in, lo_in, hi_in, rd;
    logic [3:0] reg_sel;
    logic busy, done, illegal;
  } ovec_t;

  logic clock = 1'b0;
  logic clear, start, mem_rdy;
  logic [31:0] ir;
  logic [4:0] opcode;
  logic IncPC, PCout, Zlowout, Zhighout, MDRout, Rout, MARin, PCin, MDRin;
  logic IRin, Yin, Zin, Rin, LOin, HIin, Read, busy, done, illegal;
  logic [3:0] reg_sel;

  int n_cmp = 0;
  int n_bad = 0;
  ovec_t exp_q[$];
  ovec_t act;

  always #5 clock = ~clock;

  alu_op_sequencer #(.IR_W(32), .REG_SEL_W(4)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_rdy(mem_rdy), .ir(ir),
    .opcode(opcode), .IncPC(IncPC), .PCout(PCout), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .MDRout(MDRout), .Rout(Rout), .MARin(MARin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Rin(Rin),
    .LOin(LOin), .HIin(HIin), .Read(Read), .reg_sel(reg_sel), .busy(busy),
    .done(done), .illegal(illegal)
  );

  assign act = {opcode, IncPC, PCout, Zlowout, Zhighout, MDRout, Rout, MARin,
                PCin, MDRin, IRin, Yin, Zin, Rin, LOin, HIin, Read, reg_sel,
                busy, done, illegal};

  task automatic check_vec(input string tag, input int cyc, input ovec_t want);
    n_cmp++;
    assert (act === want) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, act, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // At most one bus driver may be active in any cycle.
  always @(negedge clock) begin
    int nb;
    nb = int'(PCout) + int'(Zlowout) + int'(Zhighout) + int'(MDRout) + int'(Rout);
    n_cmp++;
    assert (nb <= 1) else begin
      n_bad++;
      $error("FAIL bus_contention observed=%0d expected<=1", nb);
    end
  end

  function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
    logic [14:0] junk;
    junk = 15'($urandom);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), junk};
  endfunction

  // Expected output sequence for one instruction, cycle 1 (T0) onward,
  // ending with one IDLE cycle.
  task automatic gen_expect(input logic [31:0] irv, input int wait_n);
    ovec_t v;
    int op;
    bit wide, unary, bad;
    op    = int'(irv[31:27]);
    wide  = (op == 4) || (op == 5);
    unary = (op == 11) || (op == 12);
    bad   = (op > 12);
    v = '0; v.busy = 1; v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.z_in = 1;
    exp_q.push_back(v);
    repeat (wait_n) begin
      v = '0; v.busy = 1; v.rd = 1; v.mdr_in = 1;
      exp_q.push_back(v);
    end
    v = '0; v.busy = 1; v.zlo_out = 1; v.pc_in = 1; v.rd = 1; v.mdr_in = 1;
    exp_q.push_back(v);
    v = '0; v.busy = 1; v.mdr_out = 1; v.ir_in = 1;
    exp_q.push_back(v);
    if (bad) begin
      v = '0; v.busy = 1; v.illegal = 1;
      exp_q.push_back(v);
    end else begin
      if (!unary) begin
        v = '0; v.busy = 1; v.r_out = 1; v.y_in = 1; v.reg_sel = irv[22:19];
        exp_q.push_back(v);
      end
      v = '0; v.busy = 1; v.r_out = 1; v.z_in = 1; v.opcode = irv[31:27];
      v.reg_sel = unary ? irv[22:19] : irv[18:15];
      exp_q.push_back(v);
      if (wide) begin
        v = '0; v.busy = 1; v.zlo_out = 1; v.lo_in = 1;
        exp_q.push_back(v);
        v = '0; v.busy = 1; v.zhi_out = 1; v.hi_in = 1; v.done = 1;
        exp_q.push_back(v);
      end else begin
        v = '0; v.busy = 1; v.zlo_out = 1; v.r_in = 1; v.reg_sel = irv[26:23]; v.done = 1;
        exp_q.push_back(v);
      end
    end
    exp_q.push_back('0);
  endtask

  task automatic run_instr(input string name, input logic [31:0] irv, input int mem_delay,
                           input int exp_lat, input bit hold, input int abort_at);
    int cyc, lat, wait_n;
    ovec_t want;
`ifdef ALU_SEQ_MEM_WAIT_EN
    wait_n = mem_delay;
`else
    wait_n = 0;
`endif
    ir = irv;
    start = 1'b1;
    mem_rdy = 1'b0;
    gen_expect(irv, wait_n);
    @(posedge clock); #1;
    start = hold;
    cyc = 1;
    lat = 0;
    while (exp_q.size() != 0) begin
      mem_rdy = (cyc >= 2 + mem_delay);
      #1;
      want = exp_q.pop_front();
      check_vec(name, cyc, want);
      if (done === 1'b1 && lat == 0) lat = cyc;
      if (cyc == abort_at) begin
        clear = 1'b1;
        exp_q.delete();
        exp_q.push_back('0);
      end
      if (exp_q.size() != 0) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    clear = 1'b0;
    mem_rdy = 1'b0;
    check_int({name, "_latency"}, lat, exp_lat);
    $display("txn %-10s ir=%h cycles=%0d done_at=%0d", name, irv, cyc, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; start = 1'b0; mem_rdy = 1'b0; ir = '0;
    repeat (3) @(posedge clock);
    #2;
    check_vec("reset", 0, '0);
    clear = 1'b0;
    @(posedge clock); #2;
    check_vec("reset_idle", 0, '0);

    run_instr("add",      mk_ir(2, 5, 2, 4),    0, 6, 1'b0, 0);
    run_instr("mul",      mk_ir(4, 1, 3, 9),    0, 7, 1'b0, 0);
    run_instr("div",      mk_ir(5, 14, 6, 11),  0, 7, 1'b0, 0);
    run_instr("shr",      mk_ir(6, 8, 12, 1),   0, 6, 1'b0, 0);
    run_instr("and",      mk_ir(0, 15, 0, 15),  0, 6, 1'b0, 0);
    run_instr("neg",      mk_ir(11, 3, 7, 0),   0, 5, 1'b0, 0);
    run_instr("not",      mk_ir(12, 9, 13, 2),  0, 5, 1'b0, 0);
    run_instr("op13",     mk_ir(13, 5, 2, 4),   0, 0, 1'b0, 0);
    run_instr("op20",     mk_ir(20, 5, 2, 4),   0, 0, 1'b0, 0);
    run_instr("op31",     mk_ir(31, 1, 1, 1),   0, 0, 1'b0, 0);
    run_instr("clr_t4",   mk_ir(2, 5, 2, 4),    0, 0, 1'b0, 5);
    run_instr("after_clr", mk_ir(3, 6, 10, 12), 0, 6, 1'b0, 0);

    clear = 1'b1; start = 1'b1; ir = mk_ir(2, 5, 2, 4);
    @(posedge clock); #2;
    check_vec("clr_start", 0, '0);
    clear = 1'b0; start = 1'b0;
    @(posedge clock); #2;
    check_vec("clr_start_idle", 0, '0);
    $display("txn %-10s clear and start together", "clr_start");

    run_instr("hold",     mk_ir(1, 2, 3, 4),    0, 6, 1'b1, 0);
    run_instr("after_hold", mk_ir(10, 7, 8, 9), 0, 6, 1'b0, 0);
`ifdef ALU_SEQ_MEM_WAIT_EN
    run_instr("mem_wait", mk_ir(2, 5, 2, 4),    3, 9, 1'b0, 0);
`else
    run_instr("mem_wait", mk_ir(2, 5, 2, 4),    3, 6, 1'b0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
